// File: rtl/upper_pc_table.sv
// rtl/upper_pc_table.sv - shared upper-PC table with CAM allocate and tree pseudo-LRU replacement
module upper_pc_table #(
   parameter int UPPER_PC_TABLE_ENTRIES     = 8,
   parameter int LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES),
   parameter int UPPER_PC_WIDTH             = 19
) (
   input  logic                                  CLK,
   input  logic                                  rst,
   input  logic                                  read_valid_REQ,
   input  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] read_index_REQ,
   output logic [UPPER_PC_WIDTH-1:0]             read_upper_PC_RESP,
   input  logic                                  update0_valid,
   input  logic [31:0]                           update0_target_full_PC,
   output logic                                  update1_valid,
   output logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] update1_upper_PC_index
);

   localparam int N     = UPPER_PC_TABLE_ENTRIES;
   localparam int L     = LOG_UPPER_PC_TABLE_ENTRIES;
   localparam int NODES = N - 1;
   localparam int LOW   = 32 - UPPER_PC_WIDTH;

   // Table state
   logic [N-1:0]              entry_valid;
   logic [UPPER_PC_WIDTH-1:0] entry_upc [N];

   // Tree PLRU, heap order: node n has children 2n+1 (lower half) and 2n+2 (upper half).
   // A node bit of 0 sends the victim search to the lower half, 1 to the upper half.
   logic [NODES-1:0]          plru;
   logic [NODES-1:0]          plru_next;

   // Update stage 1 pipeline register
   logic                      s1_valid;
   logic [UPPER_PC_WIDTH-1:0] s1_upc;

   // Stage-1 lookup results
   logic                      hit;
   logic [L-1:0]              hit_idx;
   logic                      free_found;
   logic [L-1:0]              free_idx;
   logic [L-1:0]              victim_idx;
   logic [L-1:0]              upd_idx;

   // The low target bits live in the BTB entry, not here.
   logic                      unused_low_pc;
   assign unused_low_pc = ^update0_target_full_PC[LOW-1:0];

   // Point every node on idx's root-to-leaf path away from idx.
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                   input logic [L-1:0]     idx);
      logic [NODES-1:0] t;
      logic [L-1:0]     node;
      logic             b;
      t    = tree;
      node = '0;
      for (int lvl = 0; lvl < L; lvl++) begin
         b       = idx[L-1-lvl];
         t[node] = ~b;
         node    = L'(2 * int'(node) + 1 + int'(b));
      end
      return t;
   endfunction

   // Walk the PLRU tree from the root to find the replacement victim.
   always_comb begin
      logic [L-1:0] node;
      logic         b;
      victim_idx = '0;
      node       = '0;
      b          = 1'b0;
      for (int lvl = 0; lvl < L; lvl++) begin
         b                   = plru[node];
         victim_idx[L-1-lvl] = b;
         node                = L'(2 * int'(node) + 1 + int'(b));
      end
   end

   // CAM the stage-1 upper PC and find the lowest-numbered free slot; pick hit, free, then victim.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (entry_valid[i] && (entry_upc[i] == s1_upc)) begin
            hit     = 1'b1;
            hit_idx = L'(i);
         end
         if (!entry_valid[i]) begin
            free_found = 1'b1;
            free_idx   = L'(i);
         end
      end
      if (hit) begin
         upd_idx = hit_idx;
      end else if (free_found) begin
         upd_idx = free_idx;
      end else begin
         upd_idx = victim_idx;
      end
   end

   // Read touch first, then the update touch, so the update owns any shared nodes.
   always_comb begin
      plru_next = plru;
      if (read_valid_REQ) begin
         plru_next = plru_touch(plru_next, read_index_REQ);
      end
      if (s1_valid) begin
         plru_next = plru_touch(plru_next, upd_idx);
      end
   end

   // Table, PLRU, pipeline and output registers; reads see the pre-write table contents.
   always_ff @(posedge CLK) begin
      if (rst) begin
         entry_valid            <= '0;
         for (int i = 0; i < N; i++) begin
            entry_upc[i] <= '0;
         end
         plru                   <= '0;
         s1_valid               <= 1'b0;
         s1_upc                 <= '0;
         read_upper_PC_RESP     <= '0;
         update1_valid          <= 1'b0;
         update1_upper_PC_index <= '0;
      end else begin
         if (read_valid_REQ) begin
            read_upper_PC_RESP <= entry_upc[read_index_REQ];
         end
         if (s1_valid) begin
            entry_upc[upd_idx]     <= s1_upc;
            entry_valid[upd_idx]   <= 1'b1;
            update1_upper_PC_index <= upd_idx;
         end
         update1_valid <= s1_valid;
         plru          <= plru_next;
         s1_valid      <= update0_valid;
         if (update0_valid) begin
            s1_upc <= update0_target_full_PC[31:LOW];
         end
      end
   end

endmodule

// File: tb/tb_upper_pc_table.sv
// tb/tb_upper_pc_table.sv - randomized scoreboard bench for upper_pc_table
module tb_upper_pc_table;

   logic        CLK;
   logic        rst;
   logic        read_valid_REQ;
   logic [2:0]  read_index_REQ;
   logic [18:0] read_upper_PC_RESP;
   logic        update0_valid;
   logic [31:0] update0_target_full_PC;
   logic        update1_valid;
   logic [2:0]  update1_upper_PC_index;

   upper_pc_table dut (
      .CLK                    (CLK),
      .rst                    (rst),
      .read_valid_REQ         (read_valid_REQ),
      .read_index_REQ         (read_index_REQ),
      .read_upper_PC_RESP     (read_upper_PC_RESP),
      .update0_valid          (update0_valid),
      .update0_target_full_PC (update0_target_full_PC),
      .update1_valid          (update1_valid),
      .update1_upper_PC_index (update1_upper_PC_index)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_total  = 0;
   int n_passed = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // Reference model: table as plain arrays, PLRU as a binary tree over index ranges.
   bit          m_valid [8];
   logic [18:0] m_upc   [8];
   bit          m_plru  [7];
   bit          m_s1v;
   logic [18:0] m_s1upc;
   int          m_uidx;

   logic [18:0] rd_q [$];
   int          up_q [$];
   int          obs_q [$];
   logic [18:0] last_rd = '0;

   function automatic void m_touch(input int idx);
      int lo, hi, node, mid;
      lo = 0; hi = 8; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (idx < mid) begin m_plru[node] = 1'b1; node = 2 * node + 1; hi = mid; end
         else           begin m_plru[node] = 1'b0; node = 2 * node + 2; lo = mid; end
      end
   endfunction

   function automatic int m_victim();
      int lo, hi, node, mid;
      lo = 0; hi = 8; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (m_plru[node]) begin node = 2 * node + 2; lo = mid; end
         else              begin node = 2 * node + 1; hi = mid; end
      end
      return lo;
   endfunction

   always @(posedge CLK) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_upc[i] = '0; end
         for (int i = 0; i < 7; i++) m_plru[i] = 1'b0;
         m_s1v = 1'b0;
         rd_q.push_back(19'h0);
      end else begin
         if (read_valid_REQ) rd_q.push_back(m_upc[read_index_REQ]);
         if (m_s1v) begin
            m_uidx = -1;
            for (int i = 0; i < 8; i++) if (m_valid[i] && m_upc[i] == m_s1upc) m_uidx = i;
            if (m_uidx < 0) for (int i = 7; i >= 0; i--) if (!m_valid[i]) m_uidx = i;
            if (m_uidx < 0) m_uidx = m_victim();
            m_upc[m_uidx]   = m_s1upc;
            m_valid[m_uidx] = 1'b1;
         end
         if (read_valid_REQ) m_touch(int'(read_index_REQ));
         if (m_s1v) begin
            m_touch(m_uidx);
            up_q.push_back(m_uidx);
         end
         m_s1v   = update0_valid;
         m_s1upc = update0_target_full_PC[31:13];
      end
   end

   // Monitor: compares what the DUT presents against the scoreboard queues.
   always @(negedge CLK) begin
      if (rd_q.size() > 0) last_rd = rd_q.pop_front();
      check("read_resp", {13'h0, read_upper_PC_RESP}, {13'h0, last_rd});
      check("upd_valid", {31'h0, update1_valid}, {31'h0, (up_q.size() > 0)});
      if (update1_valid && up_q.size() > 0) begin
         check("upd_index", {29'h0, update1_upper_PC_index}, up_q.pop_front());
         obs_q.push_back(int'(update1_upper_PC_index));
      end else if (up_q.size() > 0) begin
         void'(up_q.pop_front());
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         rst = 1'b0; read_valid_REQ = 1'b0; update0_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      rst = 1'b1; read_valid_REQ = 1'b0; update0_valid = 1'b0;
      @(negedge CLK);
      rst = 1'b0;
      obs_q.delete();
   endtask

   task automatic wait_obs(input int n, input string name);
      int c;
      c = 0;
      while (obs_q.size() < n && c < 20) begin @(posedge CLK); c++; end
      if (obs_q.size() < n) begin
         n_total++;
         $display("FAIL %s_timeout: got %0d responses expected %0d", name, obs_q.size(), n);
      end
   endtask

   task automatic upd(input logic [31:0] pc);
      @(negedge CLK);
      update0_valid = 1'b1; update0_target_full_PC = pc;
      @(negedge CLK);
      update0_valid = 1'b0;
   endtask

   task automatic rd(input int idx, input logic [18:0] exp, input string name);
      @(negedge CLK);
      read_valid_REQ = 1'b1; read_index_REQ = 3'(idx);
      @(negedge CLK);
      read_valid_REQ = 1'b0;
      #1 check(name, {13'h0, read_upper_PC_RESP}, {13'h0, exp});
   endtask

   logic [18:0] pool [12];

   initial begin
      rst = 1'b1; read_valid_REQ = 1'b0; read_index_REQ = '0;
      update0_valid = 1'b0; update0_target_full_PC = '0;
      repeat (2) @(negedge CLK);
      rst = 1'b0;

      // reset then read
      rd(5, 19'h0, "reset_read5");
      idle(3);
      check("reset_no_upd", {31'h0, update1_valid}, 32'h0);

      // allocate then hit
      obs_q.delete();
      upd(32'h12345678); wait_obs(1, "alloc0");
      upd(32'h12345FFC); wait_obs(2, "hit0");
      upd(32'h12346000); wait_obs(3, "alloc1");
      if (obs_q.size() >= 3) begin
         check("alloc0_idx", obs_q[0], 0);
         check("hit0_idx",   obs_q[1], 0);
         check("alloc1_idx", obs_q[2], 1);
      end
      rd(0, 19'h091A2, "read_entry0");
      rd(1, 19'h091A3, "read_entry1");

      // fill and evict
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLK);
         update0_valid = 1'b1; update0_target_full_PC = {19'(i), 13'h0};
      end
      idle(4);
      wait_obs(8, "fill");
      for (int i = 0; i < 8 && i < obs_q.size(); i++) check("fill_idx", obs_q[i], i);
      upd({19'd9, 13'h1F0}); wait_obs(9, "evict");
      if (obs_q.size() >= 9) check("evict_idx", obs_q[8], 0);
      rd(0, 19'd9, "read_evicted");

      // PLRU protection by read
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLK);
         update0_valid = 1'b1; update0_target_full_PC = {19'(i + 16), 13'h0};
      end
      idle(4);
      wait_obs(8, "fill2");
      @(negedge CLK);
      update0_valid = 1'b1; update0_target_full_PC = {19'd40, 13'h0};
      read_valid_REQ = 1'b1; read_index_REQ = 3'd0;
      @(negedge CLK);
      update0_valid = 1'b0;
      repeat (3) @(negedge CLK);
      read_valid_REQ = 1'b0;
      wait_obs(9, "protect");
      if (obs_q.size() >= 9) check("protect_idx", obs_q[8], 4);

      // back-to-back duplicate
      do_reset();
      @(negedge CLK);
      update0_valid = 1'b1; update0_target_full_PC = 32'hABCDE000;
      @(negedge CLK);
      update0_target_full_PC = 32'hABCDE004;
      @(negedge CLK);
      update0_valid = 1'b0;
      wait_obs(2, "dup");
      if (obs_q.size() >= 2) begin
         check("dup_idx0", obs_q[0], 0);
         check("dup_idx1", obs_q[1], 0);
      end
      upd(32'h00002000); wait_obs(3, "dup_next");
      if (obs_q.size() >= 3) check("dup_next_idx", obs_q[2], 1);

      // reset mid-flight
      do_reset();
      @(negedge CLK);
      update0_valid = 1'b1; update0_target_full_PC = 32'h55550000;
      @(negedge CLK);
      update0_valid = 1'b0; rst = 1'b1;
      @(negedge CLK);
      rst = 1'b0;
      idle(4);
      check("midflight_dropped", obs_q.size(), 0);
      upd(32'h77770000); wait_obs(1, "post_reset");
      if (obs_q.size() >= 1) check("post_reset_idx", obs_q[0], 0);

      // randomized traffic against the model
      for (int k = 0; k < 12; k++) pool[k] = 19'($urandom);
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge CLK);
         rst            = ($urandom_range(0, 99) < 2);
         update0_valid  = ($urandom_range(0, 99) < 60);
         update0_target_full_PC = {pool[$urandom_range(0, 11)], 13'($urandom)};
         read_valid_REQ = ($urandom_range(0, 99) < 50);
         read_index_REQ = 3'($urandom_range(0, 7));
      end
      idle(5);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
